// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock show-ahead FIFO controller driving an external simple dual-port RAM
// Ports: clk_i/srst_i clock and sync reset; data_i/wrreq_i producer side; rdreq_i/q_o consumer side;
// empty_o/full_o/usedw_o/almost_full_o/almost_empty_o registered status; ram_* RAM control and data.
module fifo_ctrl #(
    parameter int DWIDTH             = 8,
    parameter int AWIDTH             = 4,
    parameter int ALMOST_FULL_VALUE  = 12,
    parameter int ALMOST_EMPTY_VALUE = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              ram_wren_o,
    output logic [AWIDTH-1:0] ram_wrpntr_o,
    output logic [DWIDTH-1:0] ram_data_o,
    output logic [AWIDTH-1:0] ram_rdpntr_o,
    input  logic [DWIDTH-1:0] ram_q_i
);
    logic [AWIDTH:0] wr_ptr, rd_ptr, usedw_nx;
    logic            wr_ack, rd_ack;

    assign wr_ack       = wrreq_i & ~full_o & ~srst_i;
    assign rd_ack       = rdreq_i & ~empty_o & ~srst_i;
    assign ram_wren_o   = wr_ack;
    assign ram_wrpntr_o = wr_ptr[AWIDTH-1:0];
    assign ram_rdpntr_o = rd_ptr[AWIDTH-1:0];
    assign ram_data_o   = data_i;
    assign q_o          = ram_q_i;

    always_comb begin
        usedw_nx = (wr_ack && !rd_ack) ? usedw_o + (AWIDTH+1)'(1) :
                   (rd_ack && !wr_ack) ? usedw_o - (AWIDTH+1)'(1) : usedw_o;
    end

    // flags are derived from the next occupancy so they update on the same edge as the pointers
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            usedw_o        <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_full_o  <= 1'b0;
            almost_empty_o <= (ALMOST_EMPTY_VALUE > 0);
        end else begin
            wr_ptr         <= wr_ptr + {{AWIDTH{1'b0}}, wr_ack};
            rd_ptr         <= rd_ptr + {{AWIDTH{1'b0}}, rd_ack};
            usedw_o        <= usedw_nx;
            empty_o        <= usedw_nx == '0;
            full_o         <= usedw_nx == (AWIDTH+1)'(2**AWIDTH);
            almost_full_o  <= usedw_nx >= (AWIDTH+1)'(ALMOST_FULL_VALUE);
            almost_empty_o <= usedw_nx < (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed vector table plus queue-model sequences for fifo_ctrl
module tb_fifo_ctrl;
    logic       clk_i = 1'b0;
    logic       srst_i, wrreq_i, rdreq_i;
    logic [7:0] data_i, q_o, ram_data_o, ram_q_i;
    logic       empty_o, full_o, almost_full_o, almost_empty_o, ram_wren_o;
    logic [4:0] usedw_o;
    logic [3:0] ram_wrpntr_o, ram_rdpntr_o;
    logic [7:0] mem [16];

    int tests = 0;
    int errors = 0;

    fifo_ctrl dut (
        .clk_i(clk_i), .srst_i(srst_i), .data_i(data_i), .wrreq_i(wrreq_i), .rdreq_i(rdreq_i),
        .q_o(q_o), .empty_o(empty_o), .full_o(full_o), .usedw_o(usedw_o),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .ram_wren_o(ram_wren_o), .ram_wrpntr_o(ram_wrpntr_o), .ram_data_o(ram_data_o),
        .ram_rdpntr_o(ram_rdpntr_o), .ram_q_i(ram_q_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) if (ram_wren_o) mem[ram_wrpntr_o] <= ram_data_o;
    assign ram_q_i = mem[ram_rdpntr_o];

    typedef struct {
        logic       rst, wr, rd;
        logic [7:0] d;
        logic       wren;
        int         usedw;
        logic       e, f, af, ae, chkq;
        logic [7:0] q;
    } vec_t;

    vec_t       vec[$];
    logic [7:0] model[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic rst, wr, rd, input logic [7:0] d, input logic wren,
                                input int usedw, input logic e, f, af, ae, chkq, input logic [7:0] q);
        vec.push_back('{rst, wr, rd, d, wren, usedw, e, f, af, ae, chkq, q});
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, "_usedw"}, usedw_o, model.size());
        chk({tag, "_empty"}, empty_o, model.size() == 0);
        chk({tag, "_full"}, full_o, model.size() == 16);
        chk({tag, "_afull"}, almost_full_o, model.size() >= 12);
        chk({tag, "_aempty"}, almost_empty_o, model.size() < 4);
    endtask

    task automatic step(input string tag, input logic rst, wr, rd, input logic [7:0] d);
        logic wa, ra;
        srst_i = rst; wrreq_i = wr; rdreq_i = rd; data_i = d;
        wa = wr && !rst && model.size() != 16;
        ra = rd && !rst && model.size() != 0;
        #1;
        chk({tag, "_wren"}, ram_wren_o, wa);
        if (model.size() != 0) chk({tag, "_q"}, q_o, model[0]);
        @(posedge clk_i);
        if (rst) model.delete();
        if (ra) void'(model.pop_front());
        if (wa) model.push_back(d);
        #1;
        check_flags(tag);
    endtask

    initial begin
        int wcount, cyc;
        vec_t v;
        srst_i = 1'b1; wrreq_i = 1'b1; rdreq_i = 1'b1; data_i = 8'h00;

        add(1, 1, 1, 8'h11, 0, 0, 1, 0, 0, 1, 0, 8'h00);
        add(1, 1, 1, 8'h22, 0, 0, 1, 0, 0, 1, 0, 8'h00);
        add(0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 8'h00);
        add(0, 1, 0, 8'h01, 1, 2, 0, 0, 0, 1, 1, 8'h00);
        add(0, 1, 0, 8'h02, 1, 3, 0, 0, 0, 1, 1, 8'h00);
        add(0, 1, 0, 8'h03, 1, 4, 0, 0, 0, 0, 1, 8'h00);
        for (int i = 4; i < 10; i++) add(0, 1, 0, 8'(i), 1, i + 1, 0, 0, 0, 0, 1, 8'h00);
        add(0, 1, 0, 8'h0A, 1, 11, 0, 0, 0, 0, 1, 8'h00);
        add(0, 1, 0, 8'h0B, 1, 12, 0, 0, 1, 0, 1, 8'h00);
        add(0, 1, 0, 8'h0C, 1, 13, 0, 0, 1, 0, 1, 8'h00);
        add(0, 1, 0, 8'h0D, 1, 14, 0, 0, 1, 0, 1, 8'h00);
        add(0, 1, 0, 8'h0E, 1, 15, 0, 0, 1, 0, 1, 8'h00);
        add(0, 1, 0, 8'h0F, 1, 16, 0, 1, 1, 0, 1, 8'h00);
        add(0, 1, 0, 8'hAA, 0, 16, 0, 1, 1, 0, 1, 8'h00);
        add(0, 0, 1, 8'h00, 0, 15, 0, 0, 1, 0, 1, 8'h01);
        add(0, 0, 1, 8'h00, 0, 14, 0, 0, 1, 0, 1, 8'h02);
        add(0, 0, 1, 8'h00, 0, 13, 0, 0, 1, 0, 1, 8'h03);
        add(0, 0, 1, 8'h00, 0, 12, 0, 0, 1, 0, 1, 8'h04);
        for (int i = 4; i < 12; i++) add(0, 0, 1, 8'h00, 0, 15 - i, 0, 0, 0, 0, 1, 8'(i + 1));
        add(0, 0, 1, 8'h00, 0, 3, 0, 0, 0, 1, 1, 8'h0D);
        add(0, 0, 1, 8'h00, 0, 2, 0, 0, 0, 1, 1, 8'h0E);
        add(0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 1, 1, 8'h0F);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 1, 0, 8'h00);
        add(0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 1, 0, 8'h00);

        foreach (vec[i]) begin
            v = vec[i];
            srst_i = v.rst; wrreq_i = v.wr; rdreq_i = v.rd; data_i = v.d;
            #1;
            chk($sformatf("vec%0d_wren", i), ram_wren_o, v.wren);
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d_usedw", i), usedw_o, v.usedw);
            chk($sformatf("vec%0d_empty", i), empty_o, v.e);
            chk($sformatf("vec%0d_full", i), full_o, v.f);
            chk($sformatf("vec%0d_afull", i), almost_full_o, v.af);
            chk($sformatf("vec%0d_aempty", i), almost_empty_o, v.ae);
            if (v.chkq) chk($sformatf("vec%0d_q", i), q_o, v.q);
        end
        chk("underflow_rdpntr", ram_rdpntr_o, 0);
        chk("underflow_wrpntr", ram_wrpntr_o, 0);

        step("empty_rdwr", 0, 1, 1, 8'h33);
        chk("empty_rdwr_q", q_o, 8'h33);
        for (int i = 0; i < 4; i++) step("to5", 0, 1, 0, 8'(8'h34 + i));
        for (int i = 0; i < 10; i++) step("sim5", 0, 1, 1, 8'(8'h40 + i));
        chk("sim5_hold", usedw_o, 5);
        while (model.size() < 16) step("tofull", 0, 1, 0, 8'(8'h60 + model.size()));
        step("full_rdwr", 0, 1, 1, 8'hEE);
        chk("full_rdwr_usedw", usedw_o, 15);

        wcount = 0;
        cyc = 0;
        while (wcount < 100 && cyc < 2000) begin
            logic w, r;
            w = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            if (w && model.size() != 16) wcount++;
            step("rand", 0, w, r, 8'(wcount));
            cyc++;
        end
        chk("rand_budget", wcount, 100);
        cyc = 0;
        while (model.size() != 0 && cyc < 40) begin
            step("drain", 0, 0, 1, 8'h00);
            cyc++;
        end
        chk("drain_empty", empty_o, 1);

        for (int i = 0; i < 9; i++) step("to9", 0, 1, 0, 8'(8'h90 + i));
        chk("to9_usedw", usedw_o, 9);
        step("midrst", 1, 1, 1, 8'h77);
        chk("midrst_empty", empty_o, 1);
        step("post_wr", 0, 1, 0, 8'h5A);
        chk("post_wr_q", q_o, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
